// File: rtl/i2s_receiver.sv
// i2s_receiver: I2S serial-to-parallel audio deserializer, single clock (bclk).
// Captures BITSIZE-bit words MSB first, keeps the upper DATALEN bits per channel
// and strobes sample_valid once per completed stereo frame (after the right word).
// Optional macro I2S_RX_LEFT_JUSTIFIED_EN: left-justified timing (MSB on the
// lrclk edge cycle) instead of the standard one-bit-delay I2S timing.
// BITSIZE must be at least 3 and DATALEN must not exceed BITSIZE.
module i2s_receiver #(
  parameter int BITSIZE = 24,
  parameter int DATALEN = 16
) (
  input  logic               bclk,
  input  logic               reset,
  input  logic               lrclk,
  input  logic               sdata,
  output logic [DATALEN-1:0] left_out,
  output logic [DATALEN-1:0] right_out,
  output logic               sample_valid
);

  localparam int CW = $clog2(BITSIZE + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(BITSIZE);
  localparam logic [CW-1:0] CNT_LAST = CW'(BITSIZE - 1);

  logic               lr_q, lr_d;
  logic               armed_q, armed_d;
  logic               chan_q, chan_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // Only BITSIZE-1 bits need storing: the LSB arrives live on sdata at completion.
  logic [BITSIZE-2:0] shift_q, shift_d;
  logic [DATALEN-1:0] left_q, left_d;
  logic [DATALEN-1:0] right_q, right_d;
  logic               valid_q, valid_d;

  logic               lr_edge;
  logic [DATALEN-1:0] word_trunc;

  assign lr_edge = (lrclk != lr_q);

  // Upper DATALEN bits of the word {shift_q, sdata}; sdata only matters when nothing is truncated.
  generate
    if (DATALEN == BITSIZE) begin : g_full_word
      assign word_trunc = {shift_q, sdata};
    end else begin : g_trunc_word
      assign word_trunc = shift_q[BITSIZE-2 -: DATALEN];
    end
  endgenerate

  // Next-state logic: edge handling, bit capture and word completion.
  always_comb begin
    lr_d    = lrclk;
    armed_d = armed_q;
    chan_d  = chan_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    left_d  = left_q;
    right_d = right_q;
    valid_d = 1'b0;

    if (lr_edge) begin
      // A new slot starts; any unfinished word is simply abandoned.
      armed_d = 1'b1;
      chan_d  = lrclk;
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
      // Left-justified: the MSB is already present on the edge cycle.
      cnt_d   = CW'(1);
      shift_d = {{(BITSIZE-2){1'b0}}, sdata};
`else
      // I2S: one-bit delay, the edge cycle carries no data bit.
      cnt_d   = '0;
      shift_d = '0;
`endif
    end else if (armed_q && (cnt_q < CNT_FULL)) begin
      shift_d = {shift_q[BITSIZE-3:0], sdata};
      cnt_d   = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        if (chan_q) begin
          right_d = word_trunc;
          valid_d = 1'b1;
        end else begin
          left_d = word_trunc;
        end
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge bclk) begin
    if (reset) begin
      lr_q    <= 1'b0;
      armed_q <= 1'b0;
      chan_q  <= 1'b0;
      cnt_q   <= '0;
      shift_q <= '0;
      left_q  <= '0;
      right_q <= '0;
      valid_q <= 1'b0;
    end else begin
      lr_q    <= lr_d;
      armed_q <= armed_d;
      chan_q  <= chan_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      left_q  <= left_d;
      right_q <= right_d;
      valid_q <= valid_d;
    end
  end

  assign left_out     = left_q;
  assign right_out    = right_q;
  assign sample_valid = valid_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// tb_i2s_receiver: directed-vector bench for i2s_receiver (BITSIZE=24, DATALEN=16).
// Honours I2S_RX_LEFT_JUSTIFIED_EN when choosing stream alignment and expectations.
module tb_i2s_receiver;

  localparam int BITSIZE = 24;
  localparam int DATALEN = 16;
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
  localparam int OFF = 0;
  localparam bit LJ  = 1'b1;
`else
  localparam int OFF = 1;
  localparam bit LJ  = 1'b0;
`endif

  logic               bclk = 1'b0;
  logic               reset = 1'b1;
  logic               lrclk = 1'b0;
  logic               sdata = 1'b0;
  logic [DATALEN-1:0] left_out;
  logic [DATALEN-1:0] right_out;
  logic               sample_valid;

  i2s_receiver #(.BITSIZE(BITSIZE), .DATALEN(DATALEN)) dut (
    .bclk        (bclk),
    .reset       (reset),
    .lrclk       (lrclk),
    .sdata       (sdata),
    .left_out    (left_out),
    .right_out   (right_out),
    .sample_valid(sample_valid)
  );

  always #5 bclk = ~bclk;

  int cyc = 0;
  always @(posedge bclk) cyc <= cyc + 1;

  // Pulse monitor: counts high cycles of sample_valid and remembers when the last one was.
  int pulses = 0;
  int last_pulse = -1;
  always @(posedge bclk) begin
    #1;
    if (sample_valid) begin
      pulses = pulses + 1;
      last_pulse = cyc;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // One lrclk slot: data bit i of w goes out at slot offset off+i, padding is 1s.
  // If rst_at >= 0, reset is pulsed for that one cycle and the outputs checked after it.
  task automatic slot(input logic lr, input logic [23:0] w, input int len, input int off,
                      input int rst_at, output int lsb_cyc);
    lsb_cyc = -1;
    for (int i = 0; i < len; i++) begin
      @(negedge bclk);
      if (rst_at >= 0 && i == rst_at + 1) begin
        check("rst_left_zero", 32'(left_out), 32'h0);
        check("rst_right_zero", 32'(right_out), 32'h0);
        check("rst_valid_zero", 32'(sample_valid), 32'h0);
      end
      reset = (i == rst_at);
      lrclk = lr;
      if (i >= off && i < off + BITSIZE) begin
        sdata = w[BITSIZE-1-(i-off)];
        if (i == off + BITSIZE - 1) lsb_cyc = cyc;
      end else begin
        sdata = 1'b1;
      end
    end
  endtask

  // Full 32-bclk/slot stereo frame with native alignment, checked against hand values.
  task automatic frame(input string tag, input logic [23:0] l, input logic [23:0] r,
                       input logic [15:0] exp_l, input logic [15:0] exp_r);
    int p0;
    int lc;
    p0 = pulses;
    slot(1'b0, l, 32, OFF, -1, lc);
    check({tag, "_no_left_pulse"}, 32'(pulses), 32'(p0));
    slot(1'b1, r, 32, OFF, -1, lc);
    check({tag, "_left"}, 32'(left_out), 32'(exp_l));
    check({tag, "_right"}, 32'(right_out), 32'(exp_r));
    check({tag, "_one_pulse"}, 32'(pulses), 32'(p0 + 1));
    check({tag, "_pulse_time"}, 32'(last_pulse), 32'(lc + 1));
  endtask

  int lc;
  int p0;
  int t0;

  initial begin
    // Reset state
    repeat (3) @(negedge bclk);
    check("reset_left", 32'(left_out), 32'h0);
    check("reset_right", 32'(right_out), 32'h0);
    check("reset_valid", 32'(sample_valid), 32'h0);
    reset = 1'b0;

    // Start mid-slot: lrclk high, data toggling, too short to complete any word
    for (int i = 0; i < 10; i++) begin
      @(negedge bclk);
      lrclk = 1'b1;
      sdata = i[0];
    end
    check("midslot_left", 32'(left_out), 32'h0);
    check("midslot_right", 32'(right_out), 32'h0);
    check("midslot_pulses", 32'(pulses), 32'h0);

    frame("f1", 24'h123456, 24'hABCDEF, 16'h1234, 16'hABCD);

    // Short left slot (10 bits) is dropped; following right word decodes
    p0 = pulses;
    slot(1'b0, 24'hA5A5A5, OFF + 10, OFF, -1, lc);
    slot(1'b1, 24'h0F0F0F, 32, OFF, -1, lc);
    check("short_left_hold", 32'(left_out), 32'h1234);
    check("short_right", 32'(right_out), 32'h0F0F);
    check("short_pulses", 32'(pulses), 32'(p0 + 1));

    // Three back-to-back frames, pulses 64 bclk apart
    frame("f2", 24'h7FFFFF, 24'h800000, 16'h7FFF, 16'h8000);
    t0 = last_pulse;
    frame("f3", 24'h000100, 24'hFFFF00, 16'h0001, 16'hFFFF);
    check("f3_spacing", 32'(last_pulse - t0), 32'd64);
    t0 = last_pulse;
    frame("f4", 24'h00FFFF, 24'h010000, 16'h00FF, 16'h0100);
    check("f4_spacing", 32'(last_pulse - t0), 32'd64);

    // Reset for one cycle in the middle of a right word
    p0 = pulses;
    slot(1'b0, 24'h555555, 32, OFF, -1, lc);
    check("pre_rst_left", 32'(left_out), 32'h5555);
    slot(1'b1, 24'h666666, 32, OFF, 10, lc);
    check("post_rst_left", 32'(left_out), 32'h0);
    check("post_rst_right", 32'(right_out), 32'h0);
    check("post_rst_pulses", 32'(pulses), 32'(p0));
    frame("f5", 24'h111111, 24'h222222, 16'h1111, 16'h2222);

    // MSB aligned to the lrclk edge: left-justified decodes directly, I2S shifts by one
    p0 = pulses;
    slot(1'b0, 24'hC00001, 32, 0, -1, lc);
    slot(1'b1, 24'h3FFFFE, 32, 0, -1, lc);
    check("align_left", 32'(left_out), LJ ? 32'hC000 : 32'h8000);
    check("align_right", 32'(right_out), LJ ? 32'h3FFF : 32'h7FFF);
    check("align_pulses", 32'(pulses), 32'(p0 + 1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
